display_scheduler: RTL and testbench

Time-shares the six-digit 7-segment display among up to `NUM_SRC` brew-status requesters (temperature, timer, setpoint, alarm). It rotates round-robin with a fixed dwell per source, and source 0 (alarm) preempts immediately. The registered 24-bit BCD/hex word drives the existing six-digit decoder, and a per-digit blank mask provides leading-zero suppression and blinking.

---
 rtl/brew_disp_pkg.sv | 27 ++
 rtl/display_scheduler_rr_pick.sv | 31 +++
 rtl/display_scheduler.sv | 176 +++++++++++++++++
 tb/tb_display_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/brew_disp_pkg.sv
// Shared types and helpers for the brew-status display scheduler.
package brew_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    ALERT = 2'd2
  } disp_state_t;

  localparam int NUM_DIGITS = 6;
  localparam int DIGIT_W    = 4;
  localparam int WORD_W     = 24;

  // Blank leading zero digits from the top; digit 0 always stays lit.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [WORD_W-1:0] word);
    logic [NUM_DIGITS-1:0] m;
    logic                  lead;
    m    = '0;
    lead = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
      if (lead && (word[d*DIGIT_W +: DIGIT_W] == 4'h0)) m[d] = 1'b1;
      else lead = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/display_scheduler_rr_pick.sv
// Combinational round-robin finder: first requester after cur, wrapping, cur itself last.
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int SW      = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SW-1:0]      cur,
  input  logic               excl0,
  output logic [SW-1:0]      nxt,
  output logic               found
);

  localparam int IW = SW + 1;

  logic [IW-1:0] idx;

  always_comb begin
    nxt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      idx = {1'b0, cur} + IW'(i);
      if (idx >= IW'(NUM_SRC)) idx = idx - IW'(NUM_SRC);
      if (!found && req[idx[SW-1:0]] && !(excl0 && (idx == '0))) begin
        found = 1'b1;
        nxt   = idx[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Time-shares the six-digit display among requesters: round-robin with a fixed
// dwell, source 0 preempts, registered word plus blank mask for the decoder.
module display_scheduler
  import brew_disp_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DWELL      = 50_000_000,
  parameter int BLINK_HALF = 12_500_000
) (
  input  logic                      iCLK,
  input  logic                      iRST_N,
  input  logic [NUM_SRC-1:0]        iReq,
  input  logic [WORD_W*NUM_SRC-1:0] iData,
  input  logic [NUM_SRC-1:0]        iBlink,
  input  logic                      iHold,
  output logic [WORD_W-1:0]         oDig,
  output logic [NUM_DIGITS-1:0]     oBlank,
  output logic [2:0]                oSel,
  output logic                      oValid
);

  localparam int SW = $clog2(NUM_SRC);
  localparam int DW = $clog2(DWELL);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [DW-1:0] DWELL_LD   = DW'(DWELL - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  disp_state_t           state_q, state_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [SW-1:0]         last_q, last_d;
  logic [DW-1:0]         dwell_q, dwell_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic                  phase_q, phase_d;
  logic [WORD_W-1:0]     dig_q, dig_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic [2:0]            osel_q, osel_d;
  logic                  valid_q, valid_d;

  logic [SW-1:0]     pick_cur, pick_nxt;
  logic              pick_found;
  logic              expire;
  logic [WORD_W-1:0] word;
  logic              blk;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= '0;
      dwell_q <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      dig_q   <= '0;
      blank_q <= '1;
      osel_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      dig_q   <= dig_d;
      blank_q <= blank_d;
      osel_q  <= osel_d;
      valid_q <= valid_d;
    end
  end

  // After an alarm, start the search one below the preempted source so it is found first.
  always_comb begin
    case (state_q)
      SHOW:    pick_cur = sel_q;
      ALERT:   pick_cur = (last_q == '0) ? SW'(NUM_SRC - 1) : last_q - SW'(1);
      default: pick_cur = last_q;
    endcase
  end

  rr_pick #(
    .NUM_SRC(NUM_SRC),
    .SW     (SW)
  ) u_pick (
    .req  (iReq),
    .cur  (pick_cur),
    .excl0(1'b1),
    .nxt  (pick_nxt),
    .found(pick_found)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    expire  = (dwell_q == '0) && !iHold;
    case (state_q)
      IDLE: begin
        if (iReq[0]) begin
          state_d = ALERT;
          sel_d   = '0;
        end else if (pick_found) begin
          state_d = SHOW;
          sel_d   = pick_nxt;
          last_d  = pick_nxt;
          dwell_d = DWELL_LD;
        end
      end
      SHOW: begin
        if (iReq[0]) begin
          state_d = ALERT;
          sel_d   = '0;
          last_d  = sel_q;
        end else if (!iReq[sel_q] || expire) begin
          if (pick_found) begin
            sel_d   = pick_nxt;
            last_d  = pick_nxt;
            dwell_d = DWELL_LD;
          end else begin
            state_d = IDLE;
            sel_d   = '0;
          end
        end else if (!iHold) begin
          dwell_d = dwell_q - DW'(1);
        end
      end
      ALERT: begin
        if (!iReq[0]) begin
          if (pick_found) begin
            state_d = SHOW;
            sel_d   = pick_nxt;
            last_d  = pick_nxt;
            dwell_d = DWELL_LD;
          end else begin
            state_d = IDLE;
            sel_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bcnt_d  = (bcnt_q == BLINK_LAST) ? '0 : bcnt_q + BW'(1);
    phase_d = (bcnt_q == BLINK_LAST) ? ~phase_q : phase_q;
  end

  // Output register stage: word follows iData of the current selection every cycle.
  always_comb begin
    word = '0;
    blk  = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_q == SW'(k)) begin
        word = iData[k*WORD_W +: WORD_W];
        blk  = iBlink[k];
      end
    end
    osel_d = 3'(sel_q);
    if (state_q == IDLE) begin
      dig_d   = '0;
      blank_d = '1;
      valid_d = 1'b0;
    end else begin
      dig_d   = word;
      blank_d = (blk && phase_q) ? '1 : lz_mask(word);
      valid_d = 1'b1;
    end
  end

  assign oDig   = dig_q;
  assign oBlank = blank_q;
  assign oSel   = osel_q;
  assign oValid = valid_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Scenario bench for display_scheduler with NUM_SRC=4, DWELL=4, BLINK_HALF=2.
module tb_display_scheduler;

  logic        iCLK   = 1'b0;
  logic        iRST_N = 1'b0;
  logic [3:0]  iReq   = '0;
  logic [95:0] iData  = '0;
  logic [3:0]  iBlink = '0;
  logic        iHold  = 1'b0;
  logic [23:0] oDig;
  logic [5:0]  oBlank;
  logic [2:0]  oSel;
  logic        oValid;

  typedef struct packed {
    logic        valid;
    logic [2:0]  sel;
    logic [5:0]  blank;
    logic [23:0] dig;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ecount;

  display_scheduler #(
    .NUM_SRC   (4),
    .DWELL     (4),
    .BLINK_HALF(2)
  ) dut (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .iReq  (iReq),
    .iData (iData),
    .iBlink(iBlink),
    .iHold (iHold),
    .oDig  (oDig),
    .oBlank(oBlank),
    .oSel  (oSel),
    .oValid(oValid)
  );

  always #5 iCLK = ~iCLK;

  // Edges since reset release; used to predict the blink phase.
  always @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) ecount <= 0;
    else ecount <= ecount + 1;

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic push(input logic v, input logic [2:0] s, input logic [5:0] b,
                      input logic [23:0] d, input int n);
    exp_t e;
    e = {v, s, b, d};
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic test_reset();
    iRST_N = 1'b0;
    step();
    step();
    n_cmp++;
    if ({oValid, oSel, oBlank, oDig} !== {1'b0, 3'd0, 6'h3F, 24'h0}) begin
      n_bad++;
      $display("FAIL reset: got valid=%0b sel=%0d blank=%h dig=%h, want valid=0 sel=0 blank=3f dig=000000",
               oValid, oSel, oBlank, oDig);
    end
    #4 iRST_N = 1'b1;
  endtask

  task automatic test_rotation();
    exp_t e;
    iData[24*1 +: 24] = 24'h000123;
    iData[24*2 +: 24] = 24'h000045;
    iData[24*3 +: 24] = 24'h654321;
    iData[24*0 +: 24] = 24'h00E001;
    iReq = 4'b1110;
    push(1'b0, 3'd0, 6'h3F, 24'h0, 1);
    push(1'b1, 3'd1, 6'h38, 24'h000123, 4);
    push(1'b1, 3'd2, 6'h3C, 24'h000045, 4);
    push(1'b1, 3'd3, 6'h00, 24'h654321, 4);
    push(1'b1, 3'd1, 6'h38, 24'h000123, 4);
    push(1'b1, 3'd2, 6'h3C, 24'h000045, 1);
    while (sb.size() != 0) begin
      step();
      e = sb.pop_front();
      n_cmp++;
      if ({oValid, oSel, oBlank, oDig} !== e) begin
        n_bad++;
        $display("FAIL rotation t=%0t: got valid=%0b sel=%0d blank=%h dig=%h, want valid=%0b sel=%0d blank=%h dig=%h",
                 $time, oValid, oSel, oBlank, oDig, e.valid, e.sel, e.blank, e.dig);
      end
    end
  endtask

  task automatic test_preempt();
    exp_t e;
    int   j;
    iReq[0] = 1'b1;
    push(1'b1, 3'd2, 6'h3C, 24'h000045, 1);
    push(1'b1, 3'd0, 6'h30, 24'h00E001, 10);
    push(1'b1, 3'd2, 6'h3C, 24'h000045, 4);
    push(1'b1, 3'd3, 6'h00, 24'h654321, 1);
    j = 0;
    while (sb.size() != 0) begin
      if (j == 10) iReq[0] = 1'b0;
      step();
      e = sb.pop_front();
      n_cmp++;
      if ({oValid, oSel, oBlank, oDig} !== e) begin
        n_bad++;
        $display("FAIL preempt t=%0t: got valid=%0b sel=%0d blank=%h dig=%h, want valid=%0b sel=%0d blank=%h dig=%h",
                 $time, oValid, oSel, oBlank, oDig, e.valid, e.sel, e.blank, e.dig);
      end
      j++;
    end
  endtask

  task automatic test_async_reset();
    #2 iRST_N = 1'b0;
    #1;
    n_cmp++;
    if ({oValid, oSel, oBlank, oDig} !== {1'b0, 3'd0, 6'h3F, 24'h0}) begin
      n_bad++;
      $display("FAIL async_reset: got valid=%0b sel=%0d blank=%h dig=%h, want valid=0 sel=0 blank=3f dig=000000",
               oValid, oSel, oBlank, oDig);
    end
    iReq = '0;
    #3 iRST_N = 1'b1;
  endtask

  task automatic test_drop_hold();
    exp_t e;
    int   j;
    iReq  = 4'b1110;
    iHold = 1'b1;
    push(1'b0, 3'd0, 6'h3F, 24'h0, 1);
    push(1'b1, 3'd1, 6'h38, 24'h000123, 9);
    push(1'b1, 3'd2, 6'h3C, 24'h000045, 4);
    push(1'b0, 3'd0, 6'h3F, 24'h0, 2);
    j = 0;
    while (sb.size() != 0) begin
      if (j == 9)  iReq = 4'b1100;
      if (j == 13) iReq = 4'b0000;
      step();
      e = sb.pop_front();
      n_cmp++;
      if ({oValid, oSel, oBlank, oDig} !== e) begin
        n_bad++;
        $display("FAIL drop_hold t=%0t: got valid=%0b sel=%0d blank=%h dig=%h, want valid=%0b sel=%0d blank=%h dig=%h",
                 $time, oValid, oSel, oBlank, oDig, e.valid, e.sel, e.blank, e.dig);
      end
      j++;
    end
    iHold = 1'b0;
  endtask

  task automatic test_blink_zero();
    exp_t e;
    int   n;
    iData[24*3 +: 24] = 24'h000000;
    iBlink = 4'b1000;
    iReq   = 4'b1000;
    push(1'b0, 3'd0, 6'h3F, 24'h0, 1);
    for (int i = 0; i < 12; i++) begin
      n = ecount + 2 + i;
      push(1'b1, 3'd3, ((((n - 1) / 2) % 2) == 1) ? 6'h3F : 6'h3E, 24'h0, 1);
    end
    while (sb.size() != 0) begin
      step();
      e = sb.pop_front();
      n_cmp++;
      if ({oValid, oSel, oBlank, oDig} !== e) begin
        n_bad++;
        $display("FAIL blink_zero t=%0t: got valid=%0b sel=%0d blank=%h dig=%h, want valid=%0b sel=%0d blank=%h dig=%h",
                 $time, oValid, oSel, oBlank, oDig, e.valid, e.sel, e.blank, e.dig);
      end
    end
  endtask

  task automatic test_live_data();
    exp_t e;
    int   j;
    iBlink = 4'b0000;
    iReq   = 4'b0010;
    iData[24*1 +: 24] = 24'h000123;
    push(1'b1, 3'd3, 6'h3E, 24'h0, 1);
    push(1'b1, 3'd1, 6'h38, 24'h000123, 2);
    push(1'b1, 3'd1, 6'h38, 24'h000999, 6);
    j = 0;
    while (sb.size() != 0) begin
      if (j == 3) iData[24*1 +: 24] = 24'h000999;
      step();
      e = sb.pop_front();
      n_cmp++;
      if ({oValid, oSel, oBlank, oDig} !== e) begin
        n_bad++;
        $display("FAIL live_data t=%0t: got valid=%0b sel=%0d blank=%h dig=%h, want valid=%0b sel=%0d blank=%h dig=%h",
                 $time, oValid, oSel, oBlank, oDig, e.valid, e.sel, e.blank, e.dig);
      end
      j++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rotation();
    test_preempt();
    test_async_reset();
    test_drop_hold();
    test_blink_zero();
    test_live_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
